// File: rtl/qenc_pkg.sv
// qenc_pkg: shared definitions for the quadrature encoder counter.
//  - FSM state codes for the detent tracker (IDLE, R1..R3 clockwise, L1..L3 counter-clockwise)
//  - DIR_UP / DIR_DN direction codes
//  - qenc_gray():      classifies an old->new AB pair as {valid, up, illegal}
//  - qenc_state_for(): the state that matches a given AB level on the left or right side
package qenc_pkg;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StR1   = 3'd1;
  localparam logic [2:0] StR2   = 3'd2;
  localparam logic [2:0] StR3   = 3'd3;
  localparam logic [2:0] StL1   = 3'd4;
  localparam logic [2:0] StL2   = 3'd5;
  localparam logic [2:0] StL3   = 3'd6;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Both channels idle high at the detent.
  localparam logic [1:0] AB_IDLE = 2'b11;

  // Returns {valid, up, illegal}. valid: exactly one bit changed. up: the change follows the
  // clockwise Gray order 11->10->00->01->11 (B leads). illegal: both bits changed together.
  function automatic logic [2:0] qenc_gray(input logic [1:0] old_ab, input logic [1:0] new_ab);
    logic [1:0] diff;
    logic       valid;
    logic       up;
    logic       illegal;
    diff    = old_ab ^ new_ab;
    valid   = (diff == 2'b01) || (diff == 2'b10);
    illegal = (diff == 2'b11);
    case ({old_ab, new_ab})
      4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: up = 1'b1;
      default:                                up = 1'b0;
    endcase
    return {valid, up, illegal};
  endfunction

  // State consistent with AB on the given side; AB=11 always maps to IDLE.
  function automatic logic [2:0] qenc_state_for(input logic left, input logic [1:0] ab);
    logic [2:0] st;
    case (ab)
      2'b10:   st = left ? StL3 : StR1;
      2'b00:   st = left ? StL2 : StR2;
      2'b01:   st = left ? StL1 : StR3;
      default: st = StIdle;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/qenc_input_cond.sv
// qenc_input_cond: conditions one raw encoder channel.
//  2-FF synchroniser (reset to 1, the idle level). With QENC_FILTER_EN defined, a stable-level
//  filter follows: a new level is accepted only after FILTER_LEN consecutive equal samples.
// Ports:
//  i_clk    system clock
//  i_rst_n  asynchronous active-low reset
//  i_raw    raw asynchronous channel input
//  o_level  synchronised (and optionally filtered) level
// Optional feature macro: QENC_FILTER_EN
module qenc_input_cond #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_raw};
    end
  end

`ifdef QENC_FILTER_EN
  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [CntW-1:0] r_cnt;
  logic            r_level;

  // r_cnt counts consecutive samples that differ from the accepted level; any sample equal to
  // the accepted level restarts the count, so glitches shorter than FILTER_LEN are dropped.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= 1'b1;
    end else if (r_sync[1] == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CntW'(FILTER_LEN - 1)) begin
      r_level <= r_sync[1];
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_level = r_level;
`else
  logic w_unused_filter_len;
  assign w_unused_filter_len = ^FILTER_LEN;
  assign o_level = r_sync[1];
`endif

endmodule

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: quadrature rotary-encoder decoder and modulo position counter.
//  Conditions raw A/B, tracks the detent cycle with an FSM, and keeps a count modulo MAX_VAL+1.
//  MODE=0 counts once per full detent (x1); MODE=1 counts every valid Gray edge (x4).
// Ports:
//  i_clk          system clock
//  i_rst_n        asynchronous active-low reset
//  i_enc_a        raw channel A (idle high)
//  i_enc_b        raw channel B (idle high)
//  i_clear        synchronous clear of the count, wins over a simultaneous step
//  i_count_en     1: steps update the count; 0: steps reported, count holds
//  o_count        current position
//  o_step_pulse   one-cycle strobe per accepted step
//  o_dir          direction of the last step (1 = up, B leads)
//  o_wrap_pulse   one-cycle strobe when the count wraps
//  o_err_pulse    one-cycle strobe when A and B change in the same sample
//  o_busy         1 while the FSM is away from IDLE
// Optional feature macro: QENC_FILTER_EN (stable-level input filter of FILTER_LEN samples)
module quad_encoder_counter
  import qenc_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned MAX_VAL    = 19,
  parameter int unsigned MODE       = 0,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enc_a,
  input  logic             i_enc_b,
  input  logic             i_clear,
  input  logic             i_count_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_step_pulse,
  output logic             o_dir,
  output logic             o_wrap_pulse,
  output logic             o_err_pulse,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic             w_a;
  logic             w_b;
  logic [1:0]       w_ab;
  logic [2:0]       w_gray;
  logic             w_valid;
  logic             w_up;
  logic             w_illegal;
  logic             w_left;
  logic [2:0]       w_state_d;
  logic             w_step;
  logic             w_step_up;
  logic [WIDTH-1:0] w_count_d;
  logic             w_wrap;

  logic [1:0]       r_ab;
  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_step;
  logic             r_dir;
  logic             r_wrap;
  logic             r_err;
  logic             r_busy;

  qenc_input_cond #(
    .FILTER_LEN (FILTER_LEN)
  ) u_cond_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_enc_a),
    .o_level (w_a)
  );

  qenc_input_cond #(
    .FILTER_LEN (FILTER_LEN)
  ) u_cond_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_raw   (i_enc_b),
    .o_level (w_b)
  );

  assign w_ab                           = {w_a, w_b};
  assign w_gray                         = qenc_gray(r_ab, w_ab);
  assign {w_valid, w_up, w_illegal}     = w_gray;
  assign w_left = (r_state == StL1) || (r_state == StL2) || (r_state == StL3);

  // Detent tracker. The state always agrees with the current AB level, so each state has just
  // two legal neighbours: the next Gray code (advance) and the previous one (step back).
  always_comb begin
    w_state_d = r_state;
    w_step    = 1'b0;
    w_step_up = DIR_DN;
    if (w_illegal) begin
      // Resynchronise to the new level, staying on the current side (IDLE counts as right).
      w_state_d = qenc_state_for(w_left, w_ab);
    end else if (w_valid) begin
      case (r_state)
        StIdle: w_state_d = (w_ab == 2'b10) ? StR1 : StL1;
        StR1:   w_state_d = (w_ab == 2'b00) ? StR2 : StIdle;
        StR2:   w_state_d = (w_ab == 2'b01) ? StR3 : StR1;
        StR3: begin
          if (w_ab == AB_IDLE) begin
            w_state_d = StIdle;
            w_step    = (MODE == 0);
            w_step_up = DIR_UP;
          end else begin
            w_state_d = StR2;
          end
        end
        StL1:   w_state_d = (w_ab == 2'b00) ? StL2 : StIdle;
        StL2:   w_state_d = (w_ab == 2'b10) ? StL3 : StL1;
        StL3: begin
          if (w_ab == AB_IDLE) begin
            w_state_d = StIdle;
            w_step    = (MODE == 0);
            w_step_up = DIR_DN;
          end else begin
            w_state_d = StL2;
          end
        end
        default: w_state_d = StIdle;
      endcase
      // x4: every valid edge is a step; direction from the old/new AB pair.
      if (MODE != 0) begin
        w_step    = 1'b1;
        w_step_up = w_up;
      end
    end
  end

  // Modulo count next value for a step in direction w_step_up.
  always_comb begin
    w_count_d = r_count;
    w_wrap    = 1'b0;
    if (w_step_up == DIR_UP) begin
      if (r_count == MaxVal) begin
        w_count_d = '0;
        w_wrap    = 1'b1;
      end else begin
        w_count_d = r_count + WIDTH'(1);
      end
    end else begin
      if (r_count == '0) begin
        w_count_d = MaxVal;
        w_wrap    = 1'b1;
      end else begin
        w_count_d = r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ab    <= AB_IDLE;
      r_state <= StIdle;
      r_count <= '0;
      r_step  <= 1'b0;
      r_dir   <= DIR_DN;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ab    <= w_ab;
      r_state <= w_state_d;
      r_busy  <= (w_state_d != StIdle);
      r_step  <= w_step;
      r_err   <= w_illegal;
      r_wrap  <= 1'b0;
      if (w_step) begin
        r_dir <= w_step_up;
      end
      if (i_clear) begin
        r_count <= '0;
      end else if (w_step && i_count_en) begin
        r_count <= w_count_d;
        r_wrap  <= w_wrap;
      end
    end
  end

  assign o_count      = r_count;
  assign o_step_pulse = r_step;
  assign o_dir        = r_dir;
  assign o_wrap_pulse = r_wrap;
  assign o_err_pulse  = r_err;
  assign o_busy       = r_busy;

endmodule
